// File: rtl/stride_pkg.sv
// Shared types and defaults for the stride_8 frame scheduler.
package stride_pkg;

    // Output beats per stride_8 frame and the RUN-state silence limit.
    localparam int N_BEATS_DEF = 8;
    localparam int TIMEOUT_DEF = 16;

    // Width of the beat index presented to the datapath.
    localparam int BEAT_W = 3;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/stride_8_sched_if.sv
// Handshake bundle between the requesters/stride_8 unit and the scheduler.
interface stride_8_sched_if #(
    parameter int NB_CNT = 16
);
    logic              i_enable;
    logic              i_req_a;
    logic              i_req_b;
    logic              o_gnt_a;
    logic              o_gnt_b;
    logic              o_sel;
    logic              o_st_valid;
    logic              o_st_enable;
    logic              i_st_ready;
    logic              i_st_valid;
    logic [2:0]        o_beat_idx;
    logic              o_done_a;
    logic              o_done_b;
    logic              o_err;
    logic [NB_CNT-1:0] o_frame_cnt;

    // Scheduler side.
    modport slave (
        input  i_enable, i_req_a, i_req_b, i_st_ready, i_st_valid,
        output o_gnt_a, o_gnt_b, o_sel, o_st_valid, o_st_enable,
               o_beat_idx, o_done_a, o_done_b, o_err, o_frame_cnt
    );

    // Requester / stride_8 side.
    modport master (
        output i_enable, i_req_a, i_req_b, i_st_ready, i_st_valid,
        input  o_gnt_a, o_gnt_b, o_sel, o_st_valid, o_st_enable,
               o_beat_idx, o_done_a, o_done_b, o_err, o_frame_cnt
    );
endinterface

// File: rtl/stride_8_sched_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from the live requests, the
// pointer moves to the other requester whenever a grant is accepted.
module rr_arb2 (
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);
    // ptr_reg names the requester that wins a tie (0 = A, 1 = B).
    logic ptr_reg;
    logic ptr_next;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
            assign gnt[gi] = req[gi] & (~req[1 - gi] | (ptr_reg == 1'(gi)));
        end
    endgenerate

    // After serving A favour B, after serving B favour A.
    always_comb begin
        ptr_next = ptr_reg;
        if (accept) begin
            ptr_next = gnt[0];
        end
    end

    // Pointer register; reset favours A.
    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_reg <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end
endmodule

// File: rtl/stride_8_sched.sv
// Frame scheduler for a stride_8 unit: arbitrates two requesters, issues one
// load per frame, counts output beats, and guards RUN with a timeout.
module stride_8_sched
    import stride_pkg::*;
#(
    parameter int N_BEATS = N_BEATS_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int NB_CNT  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    stride_8_sched_if.slave   bus
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t              state_reg, state_next;
    logic                gnt_a_reg, gnt_a_next;
    logic                gnt_b_reg, gnt_b_next;
    logic                sel_reg, sel_next;
    logic                st_valid_reg, st_valid_next;
    logic [BEAT_W-1:0]   beat_reg, beat_next;
    logic [TMO_W-1:0]    tmo_reg, tmo_next;
    logic                done_a_reg, done_a_next;
    logic                done_b_reg, done_b_next;
    logic                err_reg, err_next;
    logic [NB_CNT-1:0]   cnt_reg, cnt_next;

    logic [1:0]          arb_gnt;
    logic                accept;

    // A grant is taken only from IDLE while enabled, so the pointer moves
    // exactly once per frame.
    assign accept = bus.i_enable && (state_reg == ST_IDLE) && (arb_gnt != 2'b00);

    rr_arb2 u_arb (
        .clk    (i_clk),
        .srst   (i_rst),
        .req    ({bus.i_req_b, bus.i_req_a}),
        .accept (accept),
        .gnt    (arb_gnt)
    );

    // Next-state and output decode; everything holds and pulses clear while
    // i_enable is low.
    always_comb begin
        state_next    = state_reg;
        gnt_a_next    = gnt_a_reg;
        gnt_b_next    = gnt_b_reg;
        sel_next      = sel_reg;
        st_valid_next = st_valid_reg;
        beat_next     = beat_reg;
        tmo_next      = tmo_reg;
        cnt_next      = cnt_reg;
        done_a_next   = 1'b0;
        done_b_next   = 1'b0;
        err_next      = 1'b0;

        if (bus.i_enable) begin
            case (state_reg)
                ST_IDLE: begin
                    beat_next = '0;
                    tmo_next  = '0;
                    if (arb_gnt != 2'b00) begin
                        state_next    = ST_LOAD;
                        gnt_a_next    = arb_gnt[0];
                        gnt_b_next    = arb_gnt[1];
                        sel_next      = arb_gnt[1];
                        st_valid_next = 1'b1;
                    end
                end
                ST_LOAD: begin
                    // Load strobe stays up until stride_8 takes it.
                    if (bus.i_st_ready) begin
                        state_next    = ST_RUN;
                        st_valid_next = 1'b0;
                        tmo_next      = '0;
                        beat_next     = '0;
                    end
                end
                ST_RUN: begin
                    if (bus.i_st_valid) begin
                        tmo_next = '0;
                        if (beat_reg == BEAT_W'(N_BEATS - 1)) begin
                            state_next  = ST_DONE;
                            beat_next   = '0;
                            done_a_next = gnt_a_reg;
                            done_b_next = gnt_b_reg;
                            cnt_next    = cnt_reg + NB_CNT'(1);
                        end else begin
                            beat_next = beat_reg + BEAT_W'(1);
                        end
                    end else if (tmo_reg == TMO_W'(TIMEOUT - 1)) begin
                        // Abandon the frame: no done pulse, no count.
                        state_next = ST_IDLE;
                        err_next   = 1'b1;
                        gnt_a_next = 1'b0;
                        gnt_b_next = 1'b0;
                        beat_next  = '0;
                        tmo_next   = '0;
                    end else begin
                        tmo_next = tmo_reg + TMO_W'(1);
                    end
                end
                ST_DONE: begin
                    // No grant here, so frames are spaced by an IDLE cycle.
                    state_next = ST_IDLE;
                    gnt_a_next = 1'b0;
                    gnt_b_next = 1'b0;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset overrides enable.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= ST_IDLE;
            gnt_a_reg    <= 1'b0;
            gnt_b_reg    <= 1'b0;
            sel_reg      <= 1'b0;
            st_valid_reg <= 1'b0;
            beat_reg     <= '0;
            tmo_reg      <= '0;
            done_a_reg   <= 1'b0;
            done_b_reg   <= 1'b0;
            err_reg      <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            gnt_a_reg    <= gnt_a_next;
            gnt_b_reg    <= gnt_b_next;
            sel_reg      <= sel_next;
            st_valid_reg <= st_valid_next;
            beat_reg     <= beat_next;
            tmo_reg      <= tmo_next;
            done_a_reg   <= done_a_next;
            done_b_reg   <= done_b_next;
            err_reg      <= err_next;
            cnt_reg      <= cnt_next;
        end
    end

    assign bus.o_gnt_a     = gnt_a_reg;
    assign bus.o_gnt_b     = gnt_b_reg;
    assign bus.o_sel       = sel_reg;
    assign bus.o_beat_idx  = beat_reg;
    assign bus.o_done_a    = done_a_reg;
    assign bus.o_done_b    = done_b_reg;
    assign bus.o_err       = err_reg;
    assign bus.o_frame_cnt = cnt_reg;

    // The stride_8 strobes follow i_enable in the same cycle so the unit is
    // never driven while the scheduler is frozen; the rest is a register.
    assign bus.o_st_valid  = st_valid_reg & bus.i_enable;
    assign bus.o_st_enable = bus.i_enable & ((state_reg == ST_LOAD) || (state_reg == ST_RUN));
endmodule

// File: tb/tb_stride_8_sched.sv
// Directed bench for stride_8_sched: a per-cycle vector table for one frame
// plus hand-written multi-cycle sequences for the corner cases.
module tb_stride_8_sched;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    int   n_valid_hi = 0;
    int   n_loads    = 0;
    int   n_err      = 0;
    int   n_done     = 0;

    stride_8_sched_if #(.NB_CNT(16)) bus ();

    stride_8_sched dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Event monitor on the falling edge.
    always @(negedge clk) begin
        if (bus.o_st_valid) n_valid_hi++;
        if (bus.o_st_valid && bus.i_st_ready) n_loads++;
        if (bus.o_err) n_err++;
        if (bus.o_done_a || bus.o_done_b) n_done++;
    end

    // ins  = {rst, en, req_a, req_b, st_ready, st_valid}
    // outs = {gnt_a, gnt_b, sel, st_valid, st_enable, done_a, done_b, err}
    typedef struct {
        logic [5:0]  ins;
        logic [7:0]  outs;
        logic [2:0]  idx;
        logic [15:0] cnt;
    } vec_t;

    vec_t vt [19];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt_a"}, 32'(bus.o_gnt_a), 0);
        chk({tag, "_gnt_b"}, 32'(bus.o_gnt_b), 0);
        chk({tag, "_sel"}, 32'(bus.o_sel), 0);
        chk({tag, "_st_valid"}, 32'(bus.o_st_valid), 0);
        chk({tag, "_st_enable"}, 32'(bus.o_st_enable), 0);
        chk({tag, "_idx"}, 32'(bus.o_beat_idx), 0);
        chk({tag, "_done"}, 32'({bus.o_done_a, bus.o_done_b}), 0);
        chk({tag, "_err"}, 32'(bus.o_err), 0);
        chk({tag, "_cnt"}, 32'(bus.o_frame_cnt), 0);
    endtask

    // One frame for the requester already asserting its request, with the
    // stride_8 unit modelled as: load taken after rdy_dly cycles, one silent
    // RUN cycle, then one beat per cycle.  stall_at inserts 12 silent cycles
    // followed by 4 disabled cycles before that beat; rst_at resets on that
    // beat; fewer than 8 beats exercises the timeout.
    task automatic frame(input bit want_b, input int rdy_dly, input int nbeats,
                         input int stall_at, input int rst_at, input int exp_cnt,
                         input string tag);
        int  v0, l0, e0, d0, waited;
        bit  got;
        v0 = n_valid_hi;
        l0 = n_loads;
        e0 = n_err;
        d0 = n_done;
        bus.i_st_ready = (rdy_dly == 0);
        bus.i_st_valid = 1'b0;
        cyc();
        chk({tag, "_gnt_a"}, 32'(bus.o_gnt_a), 32'(!want_b));
        chk({tag, "_gnt_b"}, 32'(bus.o_gnt_b), 32'(want_b));
        chk({tag, "_sel"}, 32'(bus.o_sel), 32'(want_b));
        chk({tag, "_st_enable_load"}, 32'(bus.o_st_enable), 1);
        for (int i = 0; i < rdy_dly; i++) begin
            chk({tag, "_st_valid_wait"}, 32'(bus.o_st_valid), 1);
            cyc();
        end
        bus.i_st_ready = 1'b1;
        chk({tag, "_st_valid_take"}, 32'(bus.o_st_valid), 1);
        cyc();
        bus.i_st_ready = 1'b0;
        chk({tag, "_st_valid_run"}, 32'(bus.o_st_valid), 0);
        chk({tag, "_st_enable_run"}, 32'(bus.o_st_enable), 1);
        chk({tag, "_valid_cycles"}, 32'(n_valid_hi - v0), 32'(rdy_dly + 1));
        chk({tag, "_loads"}, 32'(n_loads - l0), 1);
        cyc();
        for (int b = 0; b < nbeats; b++) begin
            if (b == stall_at) begin
                bus.i_st_valid = 1'b0;
                repeat (12) cyc();
                bus.i_enable = 1'b0;
                for (int s = 0; s < 4; s++) begin
                    cyc();
                    chk({tag, "_stall_idx"}, 32'(bus.o_beat_idx), 32'(b));
                    chk({tag, "_stall_st_enable"}, 32'(bus.o_st_enable), 0);
                    chk({tag, "_stall_st_valid"}, 32'(bus.o_st_valid), 0);
                    chk({tag, "_stall_gnt"}, 32'(want_b ? bus.o_gnt_b : bus.o_gnt_a), 1);
                end
                bus.i_enable = 1'b1;
            end
            chk($sformatf("%s_idx%0d", tag, b), 32'(bus.o_beat_idx), 32'(b));
            if (b == rst_at) begin
                rst = 1'b1;
                bus.i_st_valid = 1'b1;
                cyc();
                rst = 1'b0;
                bus.i_st_valid = 1'b0;
                chk_all_zero({tag, "_rst"});
                $display("frame %s: reset at beat %0d", tag, b);
                return;
            end
            bus.i_st_valid = 1'b1;
            cyc();
        end
        bus.i_st_valid = 1'b0;
        if (nbeats == 8) begin
            chk({tag, "_done_a"}, 32'(bus.o_done_a), 32'(!want_b));
            chk({tag, "_done_b"}, 32'(bus.o_done_b), 32'(want_b));
            chk({tag, "_cnt"}, 32'(bus.o_frame_cnt), 32'(exp_cnt));
            chk({tag, "_gnt_in_done"}, 32'(want_b ? bus.o_gnt_b : bus.o_gnt_a), 1);
            chk({tag, "_idx_done"}, 32'(bus.o_beat_idx), 0);
            if (want_b) bus.i_req_b = 1'b0;
            else bus.i_req_a = 1'b0;
            cyc();
            chk({tag, "_gnt_after"}, 32'({bus.o_gnt_a, bus.o_gnt_b}), 0);
            chk({tag, "_done_after"}, 32'({bus.o_done_a, bus.o_done_b}), 0);
            chk({tag, "_done_pulses"}, 32'(n_done - d0), 1);
            chk({tag, "_err_pulses"}, 32'(n_err - e0), 0);
        end else begin
            got = 1'b0;
            waited = 0;
            while (!got && waited < 40) begin
                cyc();
                waited++;
                if (bus.o_err) got = 1'b1;
            end
            chk({tag, "_err_seen"}, 32'(got), 1);
            chk({tag, "_err_delay"}, 32'(waited), 16);
            chk({tag, "_gnt_at_err"}, 32'({bus.o_gnt_a, bus.o_gnt_b}), 0);
            chk({tag, "_cnt_at_err"}, 32'(bus.o_frame_cnt), 32'(exp_cnt));
            if (want_b) bus.i_req_b = 1'b0;
            else bus.i_req_a = 1'b0;
            cyc();
            chk({tag, "_err_one_cycle"}, 32'(bus.o_err), 0);
            chk({tag, "_st_enable_idle"}, 32'(bus.o_st_enable), 0);
            chk({tag, "_idx_idle"}, 32'(bus.o_beat_idx), 0);
            chk({tag, "_done_pulses"}, 32'(n_done - d0), 0);
        end
        $display("frame %s: sel=%0d cnt=%0d", tag, want_b, bus.o_frame_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] outs_act;

        vt[0]  = '{6'b011010, 8'b10011000, 3'd0, 16'd0};
        vt[1]  = '{6'b011011, 8'b10001000, 3'd0, 16'd0};
        vt[2]  = '{6'b011000, 8'b10001000, 3'd0, 16'd0};
        vt[3]  = '{6'b011001, 8'b10001000, 3'd1, 16'd0};
        vt[4]  = '{6'b011001, 8'b10001000, 3'd2, 16'd0};
        vt[5]  = '{6'b011001, 8'b10001000, 3'd3, 16'd0};
        vt[6]  = '{6'b011001, 8'b10001000, 3'd4, 16'd0};
        vt[7]  = '{6'b011001, 8'b10001000, 3'd5, 16'd0};
        vt[8]  = '{6'b011001, 8'b10001000, 3'd6, 16'd0};
        vt[9]  = '{6'b011001, 8'b10001000, 3'd7, 16'd0};
        vt[10] = '{6'b011001, 8'b10000100, 3'd0, 16'd1};
        vt[11] = '{6'b010000, 8'b00000000, 3'd0, 16'd1};
        vt[12] = '{6'b010001, 8'b00000000, 3'd0, 16'd1};
        vt[13] = '{6'b010100, 8'b01111000, 3'd0, 16'd1};
        vt[14] = '{6'b010100, 8'b01111000, 3'd0, 16'd1};
        vt[15] = '{6'b000110, 8'b01100000, 3'd0, 16'd1};
        vt[16] = '{6'b010110, 8'b01101000, 3'd0, 16'd1};
        vt[17] = '{6'b100101, 8'b00000000, 3'd0, 16'd0};
        vt[18] = '{6'b010000, 8'b00000000, 3'd0, 16'd0};

        rst            = 1'b1;
        bus.i_enable   = 1'b1;
        bus.i_req_a    = 1'b0;
        bus.i_req_b    = 1'b0;
        bus.i_st_ready = 1'b0;
        bus.i_st_valid = 1'b0;
        repeat (3) cyc();
        chk_all_zero("reset");
        $display("reset: outputs idle");

        // Per-cycle vectors: A frame of 8 beats, B grant with LOAD stall and
        // a disabled cycle, then reset with enable low.
        for (int i = 0; i < 19; i++) begin
            {rst, bus.i_enable, bus.i_req_a, bus.i_req_b, bus.i_st_ready, bus.i_st_valid} = vt[i].ins;
            cyc();
            outs_act = {bus.o_gnt_a, bus.o_gnt_b, bus.o_sel, bus.o_st_valid,
                        bus.o_st_enable, bus.o_done_a, bus.o_done_b, bus.o_err};
            chk($sformatf("vec%0d_flags", i), 32'(outs_act), 32'(vt[i].outs));
            chk($sformatf("vec%0d_idx", i), 32'(bus.o_beat_idx), 32'(vt[i].idx));
            chk($sformatf("vec%0d_cnt", i), 32'(bus.o_frame_cnt), 32'(vt[i].cnt));
            $display("vec %0d: flags=%b idx=%0d cnt=%0d", i, outs_act, bus.o_beat_idx, bus.o_frame_cnt);
        end
        rst = 1'b0;
        bus.i_enable = 1'b1;
        bus.i_st_valid = 1'b0;
        bus.i_st_ready = 1'b0;

        // Simultaneous requests after reset: A first, then B.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.i_req_a = 1'b1;
        bus.i_req_b = 1'b1;
        frame(1'b0, 0, 8, -1, -1, 1, "rr_a");
        frame(1'b1, 0, 8, -1, -1, 2, "rr_b");

        // Load held off by three not-ready cycles.
        bus.i_req_a = 1'b1;
        frame(1'b0, 3, 8, -1, -1, 3, "ready_wait");

        // Long silence plus a 4-cycle disable must not time out.
        bus.i_req_a = 1'b1;
        frame(1'b0, 0, 8, 3, -1, 4, "enable_stall");

        // Five beats then silence: timeout, count unchanged.
        bus.i_req_b = 1'b1;
        frame(1'b1, 0, 5, -1, -1, 4, "timeout");

        // Reset at beat 4, then a clean restart.
        bus.i_req_a = 1'b1;
        frame(1'b0, 0, 8, -1, 4, 0, "rst_mid");
        frame(1'b0, 0, 8, -1, -1, 1, "rst_restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stride_8_sched.md
STRIDE_8_SCHED -- requirements
Module: stride_8_sched

Interface
REQ-001 Parameter N_BEATS, default 8: number of output beats per frame from the stride_8 unit.
REQ-002 Parameter TIMEOUT, default 16: maximum RUN cycles allowed without an output beat.
REQ-003 Parameter NB_CNT, default 16: width of the completed-frame counter.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 i_clk  in  1: sole clock; all state updates on its rising edge.
REQ-006 i_rst  in  1: synchronous active-high reset.
REQ-007 i_enable  in  1: global enable; low freezes all state.
REQ-008 i_req_a / i_req_b  in  1 each: requester A / B asks for one stride_8 frame; level, held until its done pulse.
REQ-009 o_gnt_a / o_gnt_b  out  1 each: grant; high from grant until the end of that frame.
REQ-010 o_sel  out  1: data-mux select for the 32 stride_8 inputs (0 = A, 1 = B); valid while a grant is high.
REQ-011 o_st_valid  out  1: load strobe to stride_8 i_valid.
REQ-012 o_st_enable  out  1: drives stride_8 i_enable.
REQ-013 i_st_ready  in  1: stride_8 o_ready; stride_8 accepts a load only while this is high.
REQ-014 i_st_valid  in  1: stride_8 o_valid; one output beat per high cycle.
REQ-015 o_beat_idx  out  3: index of the current output beat, 0..N_BEATS-1.
REQ-016 o_done_a / o_done_b  out  1 each: one-cycle pulse marking frame completion for A / B.
REQ-017 o_err  out  1: one-cycle pulse on timeout.
REQ-018 o_frame_cnt  out  NB_CNT: number of successfully completed frames, wrapping modulo 2^NB_CNT.

Function
REQ-019 The FSM SHALL have the states IDLE, LOAD, RUN and DONE.
REQ-020 IDLE: when any request is high, the block SHALL grant on the next edge (go to LOAD, set o_gnt_x and o_sel), with one-cycle grant latency.
REQ-021 Arbitration SHALL be round-robin: with both requests high, the requester not granted last wins; after reset, A has priority.
REQ-022 LOAD: o_st_valid SHALL be high while i_st_ready is low, hold until the first cycle with i_st_ready high, then go to RUN; exactly one accepted load per frame.
REQ-023 RUN: each cycle with i_st_valid high SHALL increment o_beat_idx; the N_BEATS-th beat SHALL move to DONE.
REQ-024 o_beat_idx SHALL reflect the number of beats already seen in the frame (0 at the first beat) and return to 0 in IDLE.
REQ-025 DONE (one cycle): o_done_x SHALL pulse for the granted requester, o_frame_cnt SHALL increment, the grant SHALL drop, and the next state SHALL be IDLE.
REQ-026 A new grant SHALL NOT issue in the DONE cycle; minimum frame-to-frame spacing is therefore LOAD + N_BEATS + DONE + IDLE.
REQ-027 The timeout counter SHALL clear on each beat and on entry to RUN; on reaching TIMEOUT in RUN, o_err SHALL pulse, the grant SHALL drop, the next state SHALL be IDLE, o_done SHALL NOT pulse, and o_frame_cnt SHALL NOT increment.
REQ-028 o_st_enable SHALL equal i_enable while in LOAD or RUN, and 0 otherwise.
REQ-029 With i_enable low, the FSM, counters and timeout SHALL hold, o_st_valid SHALL be 0, and pulses SHALL be suppressed.
REQ-030 i_st_valid SHALL be ignored outside RUN.
REQ-031 Dropping a request mid-frame SHALL NOT abort the frame.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 i_rst SHALL take priority over i_enable, including mid-frame.
REQ-034 On reset the block SHALL go to IDLE with all outputs at 0, o_frame_cnt = 0, the round-robin pointer favouring A, and timeout = 0.

Structure
REQ-035 State encodings and the N_BEATS/TIMEOUT defaults SHALL live in the shared package stride_pkg.
REQ-036 The round-robin arbiter SHALL be a sub-module, rr_arb2 (2 requests, 2 one-hot grants, pointer update on an accept strobe).

Verification
REQ-037 Reset, then A-only request with i_st_ready=1 and 8 beats -> o_gnt_a for 11 cycles, o_done_a pulses once, o_frame_cnt=1.
REQ-038 A and B requested simultaneously after reset -> A is served first, B second, o_sel goes 0 then 1, o_frame_cnt=2.
REQ-039 i_st_ready held low for 3 cycles in LOAD -> o_st_valid stays high for 4 cycles, with one accepted load.
REQ-040 Only 5 beats followed by silence -> o_err pulses 16 cycles after the 5th beat, no o_done, o_frame_cnt unchanged, state returns to IDLE.
REQ-041 i_enable low for 4 cycles during RUN -> o_beat_idx and the timeout counter freeze, o_st_enable=0, and the frame completes correctly afterwards.
REQ-042 i_rst asserted at beat 4 -> next cycle all outputs are 0, and the next A request restarts at o_beat_idx=0.
